// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared widths, FSM states and address/byte helpers for the L1 cache.
package l1_cache_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W = DATA_W / 8;
    localparam int OFFSET_W = 2;
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR} state_t;
    function automatic int tag_lsb(input int index_bits);
        return OFFSET_W + index_bits;
    endfunction
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
    endfunction
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] nd,
                                                      input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < BE_W; i++) r[8*i +: 8] = be[i] ? nd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/l1_cache_if.sv
// l1_cache_if: Avalon-MM style word bus used on both the CPU and RAM sides of the cache.
interface l1_cache_if;
    import l1_cache_pkg::*;
    logic read;
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0] byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic waitrequest;
    modport master (output read, write, addr, byteenable, writedata, input readdata, waitrequest);
    modport slave (input read, write, addr, byteenable, writedata, output readdata, waitrequest);
endinterface

// File: rtl/l1_cache_array.sv
// l1_cache_array: direct-mapped valid/tag/data store with combinational lookup and byte-enabled write.
module l1_cache_array
    import l1_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W = ADDR_W - OFFSET_W - INDEX_BITS
) (
    input logic clk,
    input logic reset,
    input logic [INDEX_BITS-1:0] idx,
    input logic [TAG_W-1:0] tag,
    output logic hit,
    output logic [DATA_W-1:0] data,
    input logic we,
    input logic [BE_W-1:0] be,
    input logic [DATA_W-1:0] wdata
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [DATA_W-1:0] words [LINES];
    assign hit = valid[idx] && tags[idx] == tag;
    assign data = words[idx];
    always_ff @(posedge clk or posedge reset)
        if (reset) valid <= '0;
        else if (we) valid[idx] <= 1'b1;
    // Only valid bits need clearing; tag/data are don't-care until a fill sets valid.
    always_ff @(posedge clk)
        if (we) begin
            tags[idx] <= tag;
            words[idx] <= merge_bytes(words[idx], wdata, be);
        end
endmodule

// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-through, no-write-allocate L1 cache between CPU and RAM ports.
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input logic clk,
    input logic reset,
    l1_cache_if.slave cpu,
    l1_cache_if.master ram
);
    localparam int TAG_LSB = tag_lsb(INDEX_BITS);
    localparam int TAG_W = ADDR_W - TAG_LSB;
    state_t state, state_next;
    logic hit, we;
    logic [BE_W-1:0] be;
    logic [DATA_W-1:0] line, wdata;
    l1_cache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) array_i (
        .clk(clk),
        .reset(reset),
        .idx(cpu.addr[OFFSET_W +: INDEX_BITS]),
        .tag(cpu.addr[ADDR_W-1:TAG_LSB]),
        .hit(hit),
        .data(line),
        .we(we),
        .be(be),
        .wdata(wdata)
    );
    assign cpu.readdata = hit ? line : '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        cpu.waitrequest = 1'b1;
        we = 1'b0;
        be = cpu.byteenable;
        wdata = cpu.writedata;
        case (state)
            IDLE: begin
                cpu.waitrequest = cpu.write || (cpu.read && !hit);
                state_next = cpu.write ? WR : (cpu.read && !hit) ? RD_REQ : IDLE;
            end
            RD_REQ: state_next = ram.waitrequest ? RD_REQ : RD_DATA;
            RD_DATA: begin
                we = 1'b1;
                be = '1;
                wdata = ram.readdata;
                state_next = IDLE;
            end
            WR: begin
                cpu.waitrequest = ram.waitrequest;
                we = hit && !ram.waitrequest;
                state_next = ram.waitrequest ? WR : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    // RAM request is launched from IDLE and held in registers until accepted.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ram.read <= 1'b0;
            ram.write <= 1'b0;
            ram.addr <= '0;
            ram.byteenable <= '0;
            ram.writedata <= '0;
        end else if (state == IDLE && state_next != IDLE) begin
            ram.read <= state_next == RD_REQ;
            ram.write <= state_next == WR;
            ram.addr <= word_addr(cpu.addr);
            ram.byteenable <= cpu.write ? cpu.byteenable : '1;
            ram.writedata <= cpu.writedata;
        end else if (!ram.waitrequest) begin
            ram.read <= 1'b0;
            ram.write <= 1'b0;
        end
endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: scoreboard bench with a behavioural RAM (latency 1, programmable stalls).
module tb_l1_cache;
    typedef struct {
        logic wr;
        logic [31:0] addr;
        logic [3:0] be;
        logic [31:0] data;
    } ram_op_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    l1_cache_if cpu_bus();
    l1_cache_if ram_bus();
    l1_cache #(.INDEX_BITS(4)) dut (.clk(clk), .reset(reset), .cpu(cpu_bus), .ram(ram_bus));
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    ram_op_t ram_q[$];
    logic [31:0] data_q[$];
    logic [31:0] mem [logic [31:0]];
    int stall_cycles = 0;
    int stall_cnt = 0;
    int rd_req_cycles = 0;
    int cyc = 0;
    logic acc_rd = 1'b0, acc = 1'b0, stalled = 1'b0, rd_valid = 1'b0;
    logic [31:0] acc_word = '0, rd_word = '0;
    assign ram_bus.waitrequest = stall_cnt < stall_cycles;
    assign ram_bus.readdata = rd_valid ? rd_word : {16'hBAD0, cyc[15:0]};
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction
    // RAM side: check each accepted request against the scoreboard, then act on it.
    always @(negedge clk) begin
        ram_op_t e;
        logic [31:0] w;
        acc_rd = 1'b0;
        acc = 1'b0;
        stalled = 1'b0;
        if (!reset && (ram_bus.read || ram_bus.write)) begin
            if (ram_bus.read) rd_req_cycles++;
            stalled = ram_bus.waitrequest;
            acc = !ram_bus.waitrequest;
            if (acc) begin
                checks++;
                if (ram_q.size() == 0) begin
                    failures++;
                    $display("FAIL ram_unexpected: got rd=%0b wr=%0b addr=%h, required no request",
                             ram_bus.read, ram_bus.write, ram_bus.addr);
                end else begin
                    e = ram_q.pop_front();
                    if ({ram_bus.write, ram_bus.read, ram_bus.addr, ram_bus.byteenable} !== {e.wr, !e.wr, e.addr, e.be}
                        || (e.wr && ram_bus.writedata !== e.data)) begin
                        failures++;
                        $display("FAIL ram_req: got wr=%0b rd=%0b addr=%h be=%h wd=%h, required wr=%0b addr=%h be=%h wd=%h",
                                 ram_bus.write, ram_bus.read, ram_bus.addr, ram_bus.byteenable, ram_bus.writedata,
                                 e.wr, e.addr, e.be, e.data);
                    end
                end
                if (ram_bus.write) begin
                    w = mem_rd(ram_bus.addr);
                    for (int i = 0; i < 4; i++) if (ram_bus.byteenable[i]) w[8*i +: 8] = ram_bus.writedata[8*i +: 8];
                    mem[ram_bus.addr] = w;
                end else begin
                    acc_rd = 1'b1;
                    acc_word = mem_rd(ram_bus.addr);
                end
            end
        end
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            rd_valid <= 1'b0;
            stall_cnt <= 0;
        end else begin
            rd_valid <= acc_rd;
            rd_word <= acc_word;
            stall_cnt <= stalled ? stall_cnt + 1 : acc ? 0 : stall_cnt;
        end
    end
    task automatic cpu_read(input logic [31:0] a, input logic miss, input logic [31:0] exp, input int exp_waits);
        int waits = 0;
        logic [31:0] e;
        data_q.push_back(exp);
        if (miss) ram_q.push_back('{wr: 1'b0, addr: a, be: 4'hF, data: 32'h0});
        cpu_bus.read = 1'b1;
        cpu_bus.addr = a;
        #1;
        while (cpu_bus.waitrequest && waits < 50) begin
            waits++;
            @(posedge clk);
            #2;
        end
        e = data_q.pop_front();
        checks++;
        if (cpu_bus.readdata !== e) begin
            failures++;
            $display("FAIL rd_data addr=%h: got %h, required %h", a, cpu_bus.readdata, e);
        end
        checks++;
        if (waits !== exp_waits) begin
            failures++;
            $display("FAIL rd_waits addr=%h: got %0d, required %0d", a, waits, exp_waits);
        end
        @(posedge clk);
        #1;
        cpu_bus.read = 1'b0;
    endtask
    task automatic cpu_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input int exp_waits);
        int waits = 0;
        ram_q.push_back('{wr: 1'b1, addr: a, be: be, data: d});
        cpu_bus.write = 1'b1;
        cpu_bus.addr = a;
        cpu_bus.byteenable = be;
        cpu_bus.writedata = d;
        #1;
        while (cpu_bus.waitrequest && waits < 50) begin
            waits++;
            @(posedge clk);
            #2;
        end
        checks++;
        if (waits !== exp_waits) begin
            failures++;
            $display("FAIL wr_waits addr=%h: got %0d, required %0d", a, waits, exp_waits);
        end
        @(posedge clk);
        #1;
        cpu_bus.write = 1'b0;
    endtask
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ram_bus.read, ram_bus.write, ram_bus.byteenable} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ram_ctrl: got rd=%0b wr=%0b be=%h, required 0 0 0", ram_bus.read, ram_bus.write, ram_bus.byteenable);
        end
        checks++;
        if ({ram_bus.addr, ram_bus.writedata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_ram_bus: got addr=%h wd=%h, required 0 0", ram_bus.addr, ram_bus.writedata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_bus.waitrequest, cpu_bus.readdata} !== 33'h0) begin
            failures++;
            $display("FAIL reset_cpu: got wait=%0b rd=%h, required 0 0", cpu_bus.waitrequest, cpu_bus.readdata);
        end
    endtask
    task automatic test_read_miss_hit();
        int n0 = rd_req_cycles;
        cpu_read(32'd16, 1'b1, pat(32'd16), 3);
        checks++;
        if (rd_req_cycles - n0 !== 1) begin
            failures++;
            $display("FAIL miss_read_pulse: got %0d cycles, required 1", rd_req_cycles - n0);
        end
        cpu_read(32'd16, 1'b0, pat(32'd16), 0);
        checks++;
        if (rd_req_cycles - n0 !== 1) begin
            failures++;
            $display("FAIL hit_no_ram: got %0d read cycles, required 1", rd_req_cycles - n0);
        end
    endtask
    task automatic test_conflict();
        cpu_read(32'd80, 1'b1, pat(32'd80), 3);
        mem[32'd16] = 32'h11223344;
        cpu_read(32'd16, 1'b1, 32'h11223344, 3);
    endtask
    task automatic test_write_hit();
        cpu_write(32'd16, 4'b0011, 32'hDEADBEEF, 1);
        cpu_read(32'd16, 1'b0, 32'h1122BEEF, 0);
        checks++;
        if (mem_rd(32'd16) !== 32'h1122BEEF) begin
            failures++;
            $display("FAIL ram_contents_16: got %h, required 1122beef", mem_rd(32'd16));
        end
    endtask
    task automatic test_write_miss();
        cpu_write(32'd32, 4'hF, 32'hCAFEF00D, 1);
        cpu_read(32'd32, 1'b1, 32'hCAFEF00D, 3);
    endtask
    task automatic test_stall();
        int n0 = rd_req_cycles;
        stall_cycles = 3;
        cpu_read(32'd48, 1'b1, pat(32'd48), 6);
        checks++;
        if (rd_req_cycles - n0 !== 4) begin
            failures++;
            $display("FAIL stall_read_held: got %0d cycles, required 4", rd_req_cycles - n0);
        end
        cpu_write(32'd48, 4'b1100, 32'hA5A50000, 4);
        stall_cycles = 0;
        cpu_read(32'd48, 1'b0, 32'hA5A50030, 0);
    endtask
    task automatic test_back_to_back();
        cpu_read(32'd16, 1'b0, 32'h1122BEEF, 0);
        cpu_read(32'd48, 1'b0, 32'hA5A50030, 0);
        cpu_read(32'd32, 1'b0, 32'hCAFEF00D, 0);
    endtask
    task automatic test_reset_mid_fill();
        ram_q.push_back('{wr: 1'b0, addr: 32'd112, be: 4'hF, data: 32'h0});
        cpu_bus.read = 1'b1;
        cpu_bus.addr = 32'd112;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({ram_bus.read, ram_bus.write} !== 2'b00) begin
            failures++;
            $display("FAIL abort_ram_strobes: got rd=%0b wr=%0b, required 0 0", ram_bus.read, ram_bus.write);
        end
        checks++;
        if ({cpu_bus.waitrequest, cpu_bus.readdata} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL abort_cpu: got wait=%0b rd=%h, required 1 0", cpu_bus.waitrequest, cpu_bus.readdata);
        end
        cpu_bus.read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_read(32'd112, 1'b1, pat(32'd112), 3);
        cpu_read(32'd16, 1'b1, 32'h1122BEEF, 3);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        cpu_bus.read = 1'b0;
        cpu_bus.write = 1'b0;
        cpu_bus.addr = '0;
        cpu_bus.byteenable = '0;
        cpu_bus.writedata = '0;
        test_reset();
        test_read_miss_hit();
        test_conflict();
        test_write_hit();
        test_write_miss();
        test_stall();
        test_back_to_back();
        test_reset_mid_fill();
        checks++;
        if (ram_q.size() != 0) begin
            failures++;
            $display("FAIL ram_pending: got %0d outstanding requests, required 0", ram_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
